// File: rtl/dso100fb_lcd_timing.sv
// LCD raster timing generator for the DSO100 framebuffer: H/V counters, FRAME pacing
// pulse, show-ahead FIFO pop and a registered HSYNC/VSYNC/DE/DATA panel stage.
module dso100fb_lcd_timing #(
  parameter int          H_ACTIVE  = 800,
  parameter int          H_FP      = 40,
  parameter int          H_SYNC    = 48,
  parameter int          H_BP      = 40,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 13,
  parameter int          V_SYNC    = 3,
  parameter int          V_BP      = 29,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int          DATA_W    = 24,
  parameter int          CNT_W     = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sync_enable_i,
  output logic              frame_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  output logic              underflow_o,
  input  logic              underflow_clr_i,
  output logic              lcd_hsync_o,
  output logic              lcd_vsync_o,
  output logic              lcd_de_o,
  output logic [DATA_W-1:0] lcd_data_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]  hc_q, hc_d;
  logic [CNT_W-1:0]  vc_q, vc_d;
  logic              en_q, en_d;
  logic              act0, hs0, vs0;
  logic              de_q, de_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              underflow_q, underflow_d;

  // Counters hold at (0,0) for the first enabled cycle, so a restart always begins at the origin.
  always_comb begin
    en_d = sync_enable_i;
    hc_d = hc_q;
    vc_d = vc_q;
    if (!sync_enable_i) begin
      hc_d = '0;
      vc_d = '0;
    end else if (en_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
      end else begin
        hc_d = hc_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    act0 = en_q && (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
    hs0  = en_q && (hc_q >= HS_START) && (hc_q < HS_END);
    vs0  = en_q && (vc_q >= VS_START) && (vc_q < VS_END);
  end

  assign frame_o   = en_q && (hc_q == H_LAST) && (vc_q == V_LAST);
  assign fifo_rd_o = act0 && !fifo_empty_i;

  // Underflowed pixel is blanked and skipped; setting beats a simultaneous clear.
  always_comb begin
    de_d        = act0;
    hsync_d     = hs0 ? HSYNC_POL : ~HSYNC_POL;
    vsync_d     = vs0 ? VSYNC_POL : ~VSYNC_POL;
    data_d      = (act0 && !fifo_empty_i) ? fifo_data_i : '0;
    underflow_d = (act0 && fifo_empty_i) || (underflow_q && !underflow_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hc_q        <= '0;
      vc_q        <= '0;
      en_q        <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      data_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      en_q        <= en_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  assign lcd_de_o    = de_q;
  assign lcd_hsync_o = hsync_q;
  assign lcd_vsync_o = vsync_q;
  assign lcd_data_o  = data_q;
  assign underflow_o = underflow_q;

endmodule
